// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA raster timing with pixel clock, DAC strobes and line/frame pulses
module vga_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start,
    output logic       vga_clk,
    output logic       vga_blank_n,
    output logic       vga_sync_n
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             line_wrap;
    logic             h_in_sync;
    logic             v_in_sync;
    logic             in_visible;

    assign pixel_tick  = (div_cnt == DIV_LAST);
    assign vga_blank_n = video_on;
    assign vga_sync_n  = 1'b0;

    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end

    // Next-state counters: every registered decode below looks at these so it
    // lands on the same edge as the pixel_x/pixel_y it describes.
    always_comb begin
        h_nxt     = pixel_x;
        v_nxt     = pixel_y;
        line_wrap = 1'b0;
        if (pixel_tick) begin
            if (pixel_x == H_LAST) begin
                h_nxt     = '0;
                line_wrap = 1'b1;
                v_nxt     = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                h_nxt = pixel_x + 10'd1;
            end
        end
    end

    always_comb begin
        h_in_sync  = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
        v_in_sync  = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
        in_visible = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            vga_clk     <= 1'b0;
            pixel_x     <= H_LAST;
            pixel_y     <= V_LAST;
            video_on    <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            vga_clk     <= (div_nxt >= DIV_HALF);
            pixel_x     <= h_nxt;
            pixel_y     <= v_nxt;
            video_on    <= in_visible;
            hsync       <= h_in_sync ? HS_ON : ~HS_ON;
            vsync       <= v_in_sync ? VS_ON : ~VS_ON;
            line_start  <= line_wrap;
            frame_start <= line_wrap && (v_nxt == 10'd0);
        end
    end

endmodule
